// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the generic pipeline stage register.
// State/occupancy encodings and the per-stage NOP control words.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [1:0] OCC_ZERO = 2'd0;
    localparam logic [1:0] OCC_ONE  = 2'd1;
    localparam logic [1:0] OCC_TWO  = 2'd2;

    // Strobes sit in the top bits so a bubble can never raise them.
    typedef struct packed {
        logic        we;
        logic        pc_load;
        logic        sp_inc;
        logic        sp_dec;
        logic [27:0] payload;
    } ctl_word_t;

    localparam ctl_word_t ID_EX_NOP = '{
        we:      1'b0,
        pc_load: 1'b0,
        sp_inc:  1'b0,
        sp_dec:  1'b0,
        payload: 28'h000_0013
    };

    localparam ctl_word_t EX_MEM_NOP = '{
        we:      1'b0,
        pc_load: 1'b0,
        sp_inc:  1'b0,
        sp_dec:  1'b0,
        payload: 28'h000_0000
    };

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] occ;
        occ = OCC_ZERO;
        unique case (s)
            ST_EMPTY: occ = OCC_ZERO;
            ST_ONE:   occ = OCC_ONE;
            ST_TWO:   occ = OCC_TWO;
            default:  occ = OCC_ZERO;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle between pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_stage_if #(
    parameter int WIDTH = 32
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_slot.sv
// WIDTH-bit holding register with load enable.
// Async active-high reset loads RST_VAL.
module pipe_stage_slot #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_register.sv
// Generic stage register: valid/ready handshake, 2-entry skid, NOP bubbles.
// Optional flush logic enabled by `define PIPE_STAGE_FLUSH_EN.
module pipe_stage_register
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic         CLK,
    input  logic         RST,
    pipe_stage_if.slave  prod,
    pipe_stage_if.master cons,
    input  logic         flush,
    output logic [1:0]   occupancy
);

    state_t           state_q;
    state_t           state_d;
    logic             rdy_q;
    logic             valid;
    logic             in_fire;
    logic             out_fire;
    logic             kill;
    logic             main_ld;
    logic             skid_ld;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

`ifdef PIPE_STAGE_FLUSH_EN
    assign kill = flush;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign kill         = 1'b0;
`endif

    assign valid    = (state_q != ST_EMPTY);
    assign in_fire  = prod.valid & rdy_q;
    assign out_fire = valid & cons.ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = prod.data;
        if (kill) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    unique case (1'b1)
                        in_fire && out_fire: begin
                            main_ld = 1'b1;
                        end
                        in_fire && !out_fire: begin
                            state_d = ST_TWO;
                            skid_ld = 1'b1;
                        end
                        !in_fire && out_fire: begin
                            state_d = ST_EMPTY;
                        end
                        default: begin
                            state_d = ST_ONE;
                        end
                    endcase
                end
                ST_TWO: begin
                    // Skid beat moves up once the head is consumed.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_TWO);
        end
    end

    pipe_stage_slot #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
    ) u_main (
        .CLK  (CLK),
        .RST  (RST),
        .load (main_ld),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_stage_slot #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
    ) u_skid (
        .CLK  (CLK),
        .RST  (RST),
        .load (skid_ld),
        .d    (prod.data),
        .q    (skid_q)
    );

    assign prod.ready = rdy_q;
    assign cons.valid = valid;
    assign cons.data  = valid ? main_q : BUBBLE;
    assign occupancy  = occ_of(state_q);

`ifndef SYNTHESIS
    a_full_blocks: assert property (
        @(posedge CLK) disable iff (RST)
        (state_q == ST_TWO) |-> !rdy_q
    );

    a_stall_stable: assert property (
        @(posedge CLK) disable iff (RST)
        (valid && !cons.ready && !flush) |=> $stable(cons.data)
    );
`endif

endmodule
